camac_dataway_sequencer: RTL and testbench

- Sequences one CAMAC dataway cycle per accepted command: NAF, Z (initialise) or C (clear).
- Drives N/F/A/W, B, S1, S2, Z and C with fixed phase timing, and captures R/X/Q.
- Sits between the serial command decoder and the CAMAC pins of the Messbauer CAMAC controller.
- Also owns the inhibit (I) level and the synchronised LAM (L) status.
- All CAMAC signals are active-high here; board buffers handle bus polarity.

---
 rtl/camac_dataway_sequencer_pkg.sv | 32 +++
 rtl/camac_dataway_sequencer_if.sv | 29 ++
 rtl/camac_dataway_sequencer_phase_timer.sv | 27 ++
 rtl/camac_dataway_sequencer.sv | 159 +++++++++++++++
 tb/tb_camac_dataway_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/camac_dataway_sequencer_pkg.sv
// Shared encodings for the CAMAC dataway sequencer: command types, F-code ranges,
// station limit and FSM state encoding.
package camac_dataway_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_NAF  = 2'd0,
        CMD_Z    = 2'd1,
        CMD_C    = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_type_e;

    localparam logic [4:0] F_READ_MAX  = 5'd7;
    localparam logic [4:0] F_WRITE_MIN = 5'd16;
    localparam logic [4:0] F_WRITE_MAX = 5'd23;
    localparam logic [5:0] N_MAX       = 6'd24;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE1,
        ST_GAP,
        ST_STROBE2,
        ST_HOLD
    } state_e;

    function automatic logic cmd_rejected(input logic [1:0] t, input logic [5:0] n);
        return (t == CMD_RSVD) || ((t == CMD_NAF) && ((n == 6'd0) || (n > N_MAX)));
    endfunction

endpackage

// File: rtl/camac_dataway_sequencer_if.sv
// Command/response handshake between the serial command decoder (master)
// and the dataway sequencer (slave).
interface camac_dataway_sequencer_if #(parameter int DATA_W = 24);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [5:0]        cmd_n;
    logic [4:0]        cmd_f;
    logic [3:0]        cmd_a;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_x;
    logic              rsp_q;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_type, cmd_n, cmd_f, cmd_a, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_x, rsp_q, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_n, cmd_f, cmd_a, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_x, rsp_q, rsp_err
    );

endinterface

// File: rtl/camac_dataway_sequencer_phase_timer.sv
// Loadable down counter with zero flag; one instance times every dataway phase.
// Load wins over decrement; the counter parks at zero.
module camac_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/camac_dataway_sequencer.sv
// Runs one CAMAC dataway cycle (NAF, Z or C) per accepted command with fixed phase
// timing, captures X/Q/R, and returns a response held until rsp_ready.
module camac_dataway_sequencer
    import camac_dataway_sequencer_pkg::*;
#(
    parameter int T_SETTLE = 10,
    parameter int T_S1     = 10,
    parameter int T_GAP    = 5,
    parameter int T_S2     = 5,
    parameter int T_HOLD   = 10,
    parameter int DATA_W   = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    camac_dataway_sequencer_if.slave  bus,
    input  logic                      inhibit_set,
    output logic                      lam_status,
    output logic [5:0]                camac_n,
    output logic [4:0]                camac_f,
    output logic [3:0]                camac_a,
    output logic [DATA_W-1:0]         camac_w,
    input  logic [DATA_W-1:0]         camac_r,
    input  logic                      camac_x,
    input  logic                      camac_q,
    input  logic                      camac_l,
    output logic                      camac_b,
    output logic                      camac_s1,
    output logic                      camac_s2,
    output logic                      camac_z,
    output logic                      camac_c,
    output logic                      camac_i
);

    localparam logic [TIMER_W-1:0] TV_SETTLE = TIMER_W'(T_SETTLE - 1);
    localparam logic [TIMER_W-1:0] TV_S1     = TIMER_W'(T_S1 - 1);
    localparam logic [TIMER_W-1:0] TV_GAP    = TIMER_W'(T_GAP - 1);
    localparam logic [TIMER_W-1:0] TV_S2     = TIMER_W'(T_S2 - 1);
    localparam logic [TIMER_W-1:0] TV_HOLD   = TIMER_W'(T_HOLD - 1);

    state_e              state, state_n;
    logic                go, lat_err;
    logic [1:0]          lat_type;
    logic [5:0]          lat_n;
    logic [4:0]          lat_f;
    logic [3:0]          lat_a;
    logic [DATA_W-1:0]   lat_w;
    logic                lam_meta;
    logic                tmr_load, tmr_zero;
    logic [TIMER_W-1:0]  tmr_val;
    logic                accept, is_naf, is_write, capture, finish;
    logic                active_n, rsp_valid_n, cmd_ready_n;

    camac_phase_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign is_naf   = (lat_type == CMD_NAF);
    assign is_write = (bus.cmd_type == CMD_NAF) &&
                      (bus.cmd_f >= F_WRITE_MIN) && (bus.cmd_f <= F_WRITE_MAX);

    // The accept edge only latches the command; the bus cycle starts one edge later.
    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE:    if (go && !lat_err) begin state_n = ST_SETUP;   tmr_load = 1'b1; tmr_val = TV_SETTLE; end
            ST_SETUP:   if (tmr_zero)       begin state_n = ST_STROBE1; tmr_load = 1'b1; tmr_val = TV_S1;     end
            ST_STROBE1: if (tmr_zero)       begin state_n = ST_GAP;     tmr_load = 1'b1; tmr_val = TV_GAP;    end
            ST_GAP:     if (tmr_zero)       begin state_n = ST_STROBE2; tmr_load = 1'b1; tmr_val = TV_S2;     end
            ST_STROBE2: if (tmr_zero)       begin state_n = ST_HOLD;    tmr_load = 1'b1; tmr_val = TV_HOLD;   end
            ST_HOLD:    if (tmr_zero)       begin state_n = ST_IDLE; end
            default:    state_n = ST_IDLE;
        endcase
    end

    assign capture     = (state == ST_STROBE1) && tmr_zero && is_naf;
    assign finish      = (state == ST_HOLD) && tmr_zero;
    assign active_n    = (state_n != ST_IDLE);
    assign rsp_valid_n = (bus.rsp_valid && !bus.rsp_ready) || (go && lat_err) || finish;
    assign cmd_ready_n = !active_n && !rsp_valid_n && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            go            <= 1'b0;
            lat_err       <= 1'b0;
            lat_type      <= '0;
            lat_n         <= '0;
            lat_f         <= '0;
            lat_a         <= '0;
            lat_w         <= '0;
            lam_meta      <= 1'b0;
            lam_status    <= 1'b0;
            camac_i       <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_x     <= 1'b0;
            bus.rsp_q     <= 1'b0;
            bus.rsp_err   <= 1'b0;
            camac_b       <= 1'b0;
            camac_s1      <= 1'b0;
            camac_s2      <= 1'b0;
            camac_z       <= 1'b0;
            camac_c       <= 1'b0;
            camac_n       <= '0;
            camac_f       <= '0;
            camac_a       <= '0;
            camac_w       <= '0;
        end else begin
            state      <= state_n;
            go         <= accept;
            lam_meta   <= camac_l;
            lam_status <= lam_meta;
            camac_i    <= inhibit_set;

            if (accept) begin
                lat_type      <= bus.cmd_type;
                lat_err       <= cmd_rejected(bus.cmd_type, bus.cmd_n);
                lat_n         <= (bus.cmd_type == CMD_NAF) ? bus.cmd_n : 6'd0;
                lat_f         <= (bus.cmd_type == CMD_NAF) ? bus.cmd_f : 5'd0;
                lat_a         <= (bus.cmd_type == CMD_NAF) ? bus.cmd_a : 4'd0;
                lat_w         <= is_write ? bus.cmd_wdata : '0;
                bus.rsp_rdata <= '0;
                bus.rsp_x     <= 1'b0;
                bus.rsp_q     <= 1'b0;
                bus.rsp_err   <= 1'b0;
            end
            if (go && lat_err) begin
                bus.rsp_err <= 1'b1;
            end
            if (capture) begin
                bus.rsp_x     <= camac_x;
                bus.rsp_q     <= camac_q;
                bus.rsp_rdata <= (lat_f <= F_READ_MAX) ? camac_r : '0;
            end

            bus.rsp_valid <= rsp_valid_n;
            bus.cmd_ready <= cmd_ready_n;

            camac_b  <= active_n;
            camac_s1 <= (state_n == ST_STROBE1) && is_naf;
            camac_s2 <= (state_n == ST_STROBE2);
            camac_z  <= active_n && (lat_type == CMD_Z);
            camac_c  <= active_n && (lat_type == CMD_C);
            camac_n  <= active_n ? lat_n : '0;
            camac_f  <= active_n ? lat_f : '0;
            camac_a  <= active_n ? lat_a : '0;
            camac_w  <= active_n ? lat_w : '0;
        end
    end

endmodule

// File: tb/tb_camac_dataway_sequencer.sv
// Directed and randomized checks of the dataway sequencer against a cycle-offset
// reference model derived from the phase durations.
module tb_camac_dataway_sequencer;

    localparam int DW     = 24;
    localparam int TSE    = 10;
    localparam int TS1    = 10;
    localparam int TG     = 5;
    localparam int TS2    = 5;
    localparam int TH     = 10;
    localparam int S1_LO  = 1 + TSE;
    localparam int S1_HI  = S1_LO + TS1 - 1;
    localparam int S2_LO  = S1_HI + 1 + TG;
    localparam int S2_HI  = S2_LO + TS2 - 1;
    localparam int B_HI   = S2_HI + TH;
    localparam int RSP_AT = B_HI + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inhibit_set = 1'b0;
    logic          lam_status;
    logic [5:0]    camac_n;
    logic [4:0]    camac_f;
    logic [3:0]    camac_a;
    logic [DW-1:0] camac_w;
    logic [DW-1:0] camac_r = '0;
    logic          camac_x = 1'b0;
    logic          camac_q = 1'b0;
    logic          camac_l = 1'b0;
    logic          camac_b, camac_s1, camac_s2, camac_z, camac_c, camac_i;

    int total = 0;
    int bad   = 0;

    camac_dataway_sequencer_if #(.DATA_W(DW)) bus ();

    camac_dataway_sequencer #(
        .T_SETTLE(TSE), .T_S1(TS1), .T_GAP(TG), .T_S2(TS2), .T_HOLD(TH), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .inhibit_set(inhibit_set), .lam_status(lam_status),
        .camac_n(camac_n), .camac_f(camac_f), .camac_a(camac_a), .camac_w(camac_w),
        .camac_r(camac_r), .camac_x(camac_x), .camac_q(camac_q), .camac_l(camac_l),
        .camac_b(camac_b), .camac_s1(camac_s1), .camac_s2(camac_s2),
        .camac_z(camac_z), .camac_c(camac_c), .camac_i(camac_i)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Offers a command at a negedge and returns at the negedge right after the accept edge.
    task automatic issue(input logic [1:0] t, input logic [5:0] n, input logic [4:0] f,
                         input logic [3:0] a, input logic [DW-1:0] wd, output bit ok);
        int w = 0;
        bus.cmd_type  = t;
        bus.cmd_n     = n;
        bus.cmd_f     = f;
        bus.cmd_a     = a;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = bus.cmd_ready;
        if (!ok) begin
            chk("accept_timeout", 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] n, input logic [4:0] f,
                           input logic [3:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] r,
                           input logic x, input logic q, input int hold, input bit pend);
        bit ok, naf, rej, wr, in_b;
        int len, bus_bad, i_bad, hold_bad;
        logic prev_i;
        logic [63:0] ob_b, ob_s1, ob_s2, ob_z, ob_c, ob_v, ob_rdy;
        logic [63:0] ex_b, ex_s1, ex_s2, ex_z, ex_c, ex_v;
        logic [15+DW-1:0] exp_bus;
        logic [DW+2:0] snap;

        naf = (t == 2'd0);
        rej = (t == 2'd3) || (naf && ((n == 6'd0) || (n > 6'd24)));
        wr  = naf && (f >= 5'd16) && (f <= 5'd23);
        len = rej ? 4 : RSP_AT + 1;
        camac_r = r;
        camac_x = x;
        camac_q = q;
        issue(t, n, f, a, wd, ok);
        if (!ok) return;

        {ob_b, ob_s1, ob_s2, ob_z, ob_c, ob_v, ob_rdy} = '0;
        {ex_b, ex_s1, ex_s2, ex_z, ex_c, ex_v} = '0;
        bus_bad = 0;
        i_bad   = 0;
        prev_i  = inhibit_set;
        for (int j = 0; j <= len; j++) begin
            if (j > 0) @(negedge clk);
            in_b      = !rej && (j >= 1) && (j <= B_HI);
            ex_b[j]   = in_b;
            ex_s1[j]  = in_b && naf && (j >= S1_LO) && (j <= S1_HI);
            ex_s2[j]  = in_b && (j >= S2_LO) && (j <= S2_HI);
            ex_z[j]   = in_b && (t == 2'd1);
            ex_c[j]   = in_b && (t == 2'd2);
            ex_v[j]   = (j >= (rej ? 1 : RSP_AT));
            exp_bus   = in_b ? {naf ? n : 6'd0, naf ? f : 5'd0, naf ? a : 4'd0, wr ? wd : {DW{1'b0}}} : '0;
            ob_b[j]   = camac_b;
            ob_s1[j]  = camac_s1;
            ob_s2[j]  = camac_s2;
            ob_z[j]   = camac_z;
            ob_c[j]   = camac_c;
            ob_v[j]   = bus.rsp_valid;
            ob_rdy[j] = bus.cmd_ready;
            if ({camac_n, camac_f, camac_a, camac_w} !== exp_bus) bus_bad++;
            if (camac_i !== prev_i) i_bad++;
            inhibit_set = 1'($urandom);
            prev_i      = inhibit_set;
        end
        chk("b_trace",      ob_b,   ex_b);
        chk("s1_trace",     ob_s1,  ex_s1);
        chk("s2_trace",     ob_s2,  ex_s2);
        chk("z_trace",      ob_z,   ex_z);
        chk("c_trace",      ob_c,   ex_c);
        chk("rspv_trace",   ob_v,   ex_v);
        chk("ready_trace",  ob_rdy, 64'd0);
        chk("nfaw_cycles",  64'(bus_bad), 64'd0);
        chk("inhibit_lag",  64'(i_bad),   64'd0);
        chk("rsp_err",      64'(bus.rsp_err),   64'(rej));
        chk("rsp_x",        64'(bus.rsp_x),     64'(!rej && naf && x));
        chk("rsp_q",        64'(bus.rsp_q),     64'(!rej && naf && q));
        chk("rsp_rdata",    64'(bus.rsp_rdata), (!rej && naf && (f <= 5'd7)) ? 64'(r) : 64'd0);

        snap     = {bus.rsp_rdata, bus.rsp_x, bus.rsp_q, bus.rsp_err};
        hold_bad = 0;
        if (pend) bus.cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || camac_b !== 1'b0 ||
                {bus.rsp_rdata, bus.rsp_x, bus.rsp_q, bus.rsp_err} !== snap) hold_bad++;
        end
        if (hold > 0) chk("hold_stable", 64'(hold_bad), 64'd0);

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_cleared",     64'(bus.rsp_valid), 64'd0);
        chk("ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
        chk("idle_after_rsp",  64'(camac_b),       64'd0);
    endtask

    initial begin
        bit ok;
        logic [1:0] rt;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = '0;
        bus.cmd_n     = '0;
        bus.cmd_f     = '0;
        bus.cmd_a     = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_bus", 64'({camac_b, camac_s1, camac_s2, camac_z, camac_c, camac_i, camac_n, camac_f, camac_a, camac_w}), 64'd0);
        rst = 1'b0;

        camac_l = 1'b1;
        inhibit_set = 1'b1;
        @(negedge clk);
        chk("lam_first_flop", 64'(lam_status), 64'd0);
        chk("inhibit_on",     64'(camac_i),    64'd1);
        @(negedge clk);
        chk("lam_second_flop", 64'(lam_status), 64'd1);
        camac_l = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lam_clear", 64'(lam_status), 64'd0);

        run_cmd(2'd0, 6'd5, 5'd0, 4'd2, 24'h0, 24'hA5A5A5, 1'b1, 1'b1, 0, 1'b0);
        run_cmd(2'd0, 6'd3, 5'd16, 4'd0, 24'h123456, 24'hFFFFFF, 1'b1, 1'b0, 20, 1'b1);
        run_cmd(2'd0, 6'd3, 5'd16, 4'd0, 24'h123456, 24'hFFFFFF, 1'b1, 1'b0, 0, 1'b0);
        run_cmd(2'd1, 6'd9, 5'd3, 4'd7, 24'hABCDEF, 24'h777777, 1'b1, 1'b1, 2, 1'b0);
        run_cmd(2'd2, 6'd1, 5'd0, 4'd1, 24'h0, 24'h111111, 1'b1, 1'b1, 1, 1'b0);
        run_cmd(2'd0, 6'd0, 5'd0, 4'd0, 24'h0, 24'h222222, 1'b1, 1'b1, 0, 1'b0);
        run_cmd(2'd0, 6'd25, 5'd0, 4'd0, 24'h0, 24'h333333, 1'b1, 1'b1, 0, 1'b0);
        run_cmd(2'd3, 6'd4, 5'd1, 4'd0, 24'h0, 24'h444444, 1'b1, 1'b1, 0, 1'b0);
        run_cmd(2'd0, 6'd24, 5'd7, 4'd15, 24'h0, 24'h5A5A5A, 1'b0, 1'b1, 0, 1'b0);

        // Reset during S1: everything must drop and no response may appear.
        camac_r = 24'hC3C3C3;
        issue(2'd0, 6'd7, 5'd2, 4'd1, 24'h0, ok);
        if (ok) begin
            repeat (15) @(negedge clk);
            chk("mid_s1_active", 64'(camac_s1), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_bus", 64'({camac_b, camac_s1, camac_s2, camac_z, camac_c, camac_n, camac_f, camac_a, camac_w}), 64'd0);
            chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
            repeat (30) @(negedge clk);
            chk("abort_no_late_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        run_cmd(2'd0, 6'd12, 5'd20, 4'd3, 24'h0F0F0F, 24'h999999, 1'b1, 1'b1, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rt = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            run_cmd(rt, 6'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 4'($urandom),
                    24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
